// File: rtl/pcs_sync_fsm_param.sv
// Code-group synchroniser: acquires comma/data alignment, tracks even/odd slot parity
// and a leaky bad-level counter, and counts sync->loss transitions.
module pcs_sync_fsm_param #(
    parameter int ACQ_PAIRS = 3,
    parameter int GOOD_RUN  = 3,
    parameter int BAD_LIMIT = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             signal_detect,
    input  logic [9:0]       rx_code_group,
    output logic             code_status,
    output logic [9:0]       rx_code_group_out,
    output logic             rx_even,
    output logic             comma_det,
    output logic [CNT_W-1:0] loss_events
);

    localparam logic [1:0] LOSS_OF_SYNC  = 2'd0;
    localparam logic [1:0] COMMA_DETECT  = 2'd1;
    localparam logic [1:0] ACQUIRE_SYNC  = 2'd2;
    localparam logic [1:0] SYNC_ACQUIRED = 2'd3;

    localparam logic [2:0] ACQ_N    = 3'(ACQ_PAIRS);
    localparam logic [2:0] BAD_TOP  = 3'(BAD_LIMIT - 1);
    localparam logic [3:0] GOOD_TOP = 4'(GOOD_RUN - 1);

    function automatic logic [3:0] popcnt(input logic [9:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    logic [1:0] state, state_d;
    logic [2:0] acq_cnt, acq_d;
    logic [2:0] level, level_d;
    logic [3:0] good_cnt, good_d;
    logic       even_d, loss_inc;
    logic       comma, valid, slot_even, cgbad;
    logic [3:0] pop_all, pop_hi, pop_lo;

    assign pop_all   = popcnt(rx_code_group);
    assign pop_hi    = popcnt({4'd0, rx_code_group[9:4]});
    assign pop_lo    = popcnt({6'd0, rx_code_group[3:0]});
    assign comma     = (rx_code_group[9:3] == 7'b1100000) || (rx_code_group[9:3] == 7'b0011111);
    assign valid     = (pop_all >= 4'd4) && (pop_all <= 4'd6) &&
                       (pop_hi  >= 4'd2) && (pop_hi  <= 4'd4) &&
                       (pop_lo  >= 4'd1) && (pop_lo  <= 4'd3);
    assign slot_even = !rx_even;
    assign cgbad     = !valid || (comma && !slot_even);

    always_comb begin
        state_d  = state;
        even_d   = !rx_even;
        acq_d    = acq_cnt;
        level_d  = level;
        good_d   = good_cnt;
        loss_inc = 1'b0;
        if (!signal_detect) begin
            state_d  = LOSS_OF_SYNC;
            acq_d    = 3'd0;
            level_d  = 3'd0;
            good_d   = 4'd0;
            loss_inc = (state == SYNC_ACQUIRED);
        end else begin
            case (state)
                LOSS_OF_SYNC: if (comma) begin
                    state_d = COMMA_DETECT;
                    even_d  = 1'b1;
                    acq_d   = 3'd1;
                end
                COMMA_DETECT: begin
                    if (valid && !comma) begin
                        if (acq_cnt == ACQ_N) begin
                            state_d = SYNC_ACQUIRED;
                            level_d = 3'd0;
                            good_d  = 4'd0;
                        end else begin
                            state_d = ACQUIRE_SYNC;
                        end
                    end else begin
                        state_d = LOSS_OF_SYNC;
                    end
                end
                ACQUIRE_SYNC: begin
                    // cgbad already rejects an odd-slot comma, so any comma here is even
                    if (cgbad) begin
                        state_d = LOSS_OF_SYNC;
                    end else if (comma) begin
                        state_d = COMMA_DETECT;
                        even_d  = 1'b1;
                        acq_d   = acq_cnt + 3'd1;
                    end
                end
                default: begin
                    if (cgbad) begin
                        good_d = 4'd0;
                        if (level == BAD_TOP) begin
                            state_d  = LOSS_OF_SYNC;
                            level_d  = 3'd0;
                            loss_inc = 1'b1;
                        end else begin
                            level_d = level + 3'd1;
                        end
                    end else if (level != 3'd0) begin
                        if (good_cnt == GOOD_TOP) begin
                            level_d = level - 3'd1;
                            good_d  = 4'd0;
                        end else begin
                            good_d = good_cnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state             <= LOSS_OF_SYNC;
            acq_cnt           <= 3'd0;
            level             <= 3'd0;
            good_cnt          <= 4'd0;
            rx_even           <= 1'b0;
            code_status       <= 1'b0;
            rx_code_group_out <= 10'd0;
            comma_det         <= 1'b0;
            loss_events       <= '0;
        end else begin
            state             <= state_d;
            acq_cnt           <= acq_d;
            level             <= level_d;
            good_cnt          <= good_d;
            rx_even           <= even_d;
            code_status       <= (state_d == SYNC_ACQUIRED);
            rx_code_group_out <= rx_code_group;
            comma_det         <= comma;
            if (loss_inc && (loss_events != {CNT_W{1'b1}}))
                loss_events <= loss_events + 1'b1;
        end
    end

endmodule

// File: doc/pcs_sync_fsm_param.md
Name: pcs_sync_fsm_param

Overview:
- Parametrised 1000BASE-X style code-group synchroniser and next generation of the current synchroniser.
- Takes one 10-bit code group per clock, acquires alignment from comma/data pairs and reports code_status.
- Tracks even/odd slot parity and counts loss-of-sync events.
- Acquisition depth, good-run recovery length and bad-level loss limit are all parameters.
- Sits between the deserialiser/aligner and the 8B/10B decoder / receive FSM.

Parameters:
ACQ_PAIRS, 3, comma/data pairs required to reach sync (1..7)
GOOD_RUN, 3, consecutive good code groups that lower the bad level by one (1..15)
BAD_LIMIT, 4, bad level at which sync is lost (1..7)
CNT_W, 8, width of the loss_events counter

Ports:
clk  input  1  clock; one code group per rising edge
RESET  input  1  asynchronous, active-low reset
signal_detect  input  1  PMA signal present; low forces loss of sync
rx_code_group  input  10  received code group, bit 9 = 'a'
code_status  output  1  1 = synchronised
rx_code_group_out  output  10  rx_code_group registered, 1-cycle latency
rx_even  output  1  1 = rx_code_group_out occupies an even slot
comma_det  output  1  registered comma flag aligned with rx_code_group_out
loss_events  output  CNT_W  saturating count of sync→loss transitions

Behaviour:
- Reset:
  - RESET low immediately clears all outputs and state: code_status=0, rx_code_group_out=0, rx_even=0, comma_det=0, loss_events=0, state=LOSS_OF_SYNC, counters=0.
  - Reset asserted mid-operation has the same effect.
  - Release takes effect on the next clk edge.
- Classification (combinational on rx_code_group):
  - comma = rx_code_group[9:3] is 7'b1100000 or 7'b0011111.
  - valid requires all three: popcount[9:0] in {4,5,6}, popcount[9:4] in {2,3,4}, popcount[3:0] in {1,2,3}.
  - slot_even = !rx_even; the incoming group's slot is the opposite of the previous group's slot.
  - cgbad = !valid OR (comma AND !slot_even).
  - cggood = !cgbad.
- Registered outputs: rx_code_group_out, comma_det, rx_even and code_status all update on the same edge that samples rx_code_group.
- FSM (one transition per edge):
  - Priority: signal_detect=0 overrides every rule below and gives next state LOSS_OF_SYNC.
  - LOSS_OF_SYNC:
    - code_status=0; rx_even toggles.
    - comma → COMMA_DETECT, rx_even=1, acq_cnt=1.
  - COMMA_DETECT:
    - rx_even toggles.
    - valid non-comma → if acq_cnt==ACQ_PAIRS go to SYNC_ACQUIRED (level=0, good_cnt=0), else go to ACQUIRE_SYNC.
    - Anything else → LOSS_OF_SYNC.
  - ACQUIRE_SYNC:
    - cgbad → LOSS_OF_SYNC.
    - comma with slot_even → COMMA_DETECT, rx_even=1, acq_cnt+1.
    - Other cggood → stay, rx_even toggles.
  - SYNC_ACQUIRED:
    - code_status=1; rx_even toggles each cycle.
    - cgbad → level+1, good_cnt=0.
    - cggood at level>0 → good_cnt+1; when good_cnt reaches GOOD_RUN, level-1 and good_cnt=0.
    - cggood at level 0 → no change.
    - If level would reach BAD_LIMIT → LOSS_OF_SYNC, code_status=0, loss_events+1.
- code_status:
  - Rises on the edge that samples the data group completing the ACQ_PAIRS-th pair.
  - Falls on the edge that samples the BAD_LIMIT-th bad group or signal_detect=0.
- loss_events:
  - Increments only on SYNC_ACQUIRED→LOSS_OF_SYNC, including signal_detect drop while in sync.
  - Saturates at all-ones.
- Simultaneous events:
  - signal_detect=0 with a comma → LOSS_OF_SYNC; the comma is ignored.
  - cgbad at level BAD_LIMIT-1 while good_cnt==GOOD_RUN-1 → bad wins (loss).

Test Plan:
- Reset, signal_detect=1, feed D5.6 (1010010110) ×4 → code_status=0, loss_events=0.
- K28.5 (1100000101), D5.6, K28.5, D5.6, K28.5, D5.6 → code_status=1 on the 6th edge; rx_even=1 alongside each K28.5 on rx_code_group_out; rx_code_group_out lags input by 1 cycle.
- In sync, feed 0000000000 ×3 → code_status stays 1; a 4th → code_status=0 and loss_events=1 on that edge.
- In sync, feed 1 invalid, then 3 valid D1.0 (1000101011), then 3 invalid → code_status stays 1 (level returned to 0, then reached 3).
- During acquisition (after K28.5, D5.6), present K28.5 on an odd slot → LOSS_OF_SYNC; full re-acquisition needed. Repeat with ACQ_PAIRS=1: K28.5, D5.6 → code_status=1 after 2 groups.
- In sync, drive signal_detect=0 for 1 cycle → code_status=0 next edge, loss_events+1. Then pulse RESET low mid-sync → all outputs 0 immediately, before the next clk edge.
